// File: rtl/switch_input_port.sv
// Switch-bank input port: synchronises SW_IN/BTN_IN, debounces the enter button and
// captures SW_IN once per press. Define SWITCH_INPUT_PORT_FIFO_EN for 4-entry FIFO storage.
module switch_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] SW_IN,
  input  logic       BTN_IN,
  input  logic       RD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       OVERRUN
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_LIM = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic          r_btn_m, r_btn_s;
  logic [DW-1:0] r_sw_m, r_sw_s;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          w_cap;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_ovr;
  logic          w_rd;
  logic          w_wr;

  // Two-flop synchronisers on the raw inputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_btn_m <= 1'b0;
      r_btn_s <= 1'b0;
      r_sw_m  <= '0;
      r_sw_s  <= '0;
    end else begin
      r_btn_m <= BTN_IN;
      r_btn_s <= r_btn_m;
      r_sw_m  <= SW_IN;
      r_sw_s  <= r_sw_m;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  // Debouncer: a level must be stable DEBOUNCE_CYCLES counted cycles before acceptance
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_btn_s) w_state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!r_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LIM) begin
          w_state_nxt = PRESSED;
          w_cap       = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!r_btn_s) w_state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (r_btn_s) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == CNT_LIM) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SWITCH_INPUT_PORT_FIFO_EN
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned NW    = 3;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp, w_rp_nxt;
  logic [NW-1:0] r_fcnt, w_fcnt_nxt;
  logic          w_full;
  logic [DW-1:0] w_head_nxt;

  assign w_full     = (r_fcnt == NW'(DEPTH));
  assign w_rd       = RD & (r_fcnt != '0);
  assign w_wr       = w_cap & (~w_full | w_rd);
  assign w_rp_nxt   = w_rd ? r_rp + PW'(1) : r_rp;
  assign w_fcnt_nxt = r_fcnt + NW'(w_wr) - NW'(w_rd);
  // New head may be the word written this very cycle
  assign w_head_nxt = (w_wr && (r_wp == w_rp_nxt)) ? r_sw_s : r_mem[w_rp_nxt];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_fcnt  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= r_sw_s;
        r_wp        <= r_wp + PW'(1);
      end
      r_rp    <= w_rp_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_valid <= (w_fcnt_nxt != '0);
      if (w_fcnt_nxt != '0) r_data <= w_head_nxt;
      if (w_cap && w_full && !w_rd) r_ovr <= 1'b1;
      else if (w_rd && (w_fcnt_nxt == '0)) r_ovr <= 1'b0;
    end
  end
`else
  assign w_rd = RD & r_valid;
  assign w_wr = w_cap & (~r_valid | w_rd);

  // Single holding register; full whenever it holds unread data
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_data  <= r_sw_s;
        r_valid <= 1'b1;
      end else if (w_rd) begin
        r_valid <= 1'b0;
      end
      if (w_cap && r_valid && !w_rd) r_ovr <= 1'b1;
      else if (w_rd && !w_wr) r_ovr <= 1'b0;
    end
  end
`endif

  assign DATA    = r_data;
  assign VALID   = r_valid;
  assign OVERRUN = r_ovr;

endmodule

// File: tb/tb_switch_input_port.sv
// Bench for switch_input_port: directed scenarios plus random button/RD traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_switch_input_port;

  localparam int unsigned D = 4;
`ifdef SWITCH_INPUT_PORT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw_in = 8'h00;
  logic       btn_in = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  switch_input_port #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .SW_IN  (sw_in),
    .BTN_IN (btn_in),
    .RD     (rd),
    .DATA   (data),
    .VALID  (valid),
    .OVERRUN(overrun)
  );

  always #5 clk = ~clk;

  // Model: inputs seen two edges late; level accepted after D+2 consecutive differing samples
  logic       m_bd1, m_bd2, m_acc;
  logic [7:0] m_sd1, m_sd2, m_last;
  int         m_run;
  logic       m_ovr;
  logic [7:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_bd1 = 0; m_bd2 = 0; m_acc = 0; m_sd1 = 0; m_sd2 = 0;
    m_last = 0; m_run = 0; m_ovr = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic       cap;
    logic       rd_eff;
    logic [7:0] ss;
    cap = 0;
    ss  = m_sd2;
    if (m_bd2 != m_acc) m_run++;
    else m_run = 0;
    if (m_run == int'(D) + 2) begin
      m_acc = m_bd2;
      m_run = 0;
      cap   = m_acc;
    end
    rd_eff = rd && (m_q.size() > 0);
    if (rd_eff) m_last = m_q.pop_front();
    if (cap) begin
      if (m_q.size() < DEPTH) m_q.push_back(ss);
      else m_ovr = 1;
    end
    if (rd_eff && m_q.size() == 0) m_ovr = 0;
    m_bd2 = m_bd1; m_bd1 = btn_in;
    m_sd2 = m_sd1; m_sd1 = sw_in;
  endtask

  // One clock edge: advance the model, then compare outputs 1ns later
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("valid", 32'(valid), 32'(m_q.size() > 0));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("data", 32'(data), 32'((m_q.size() > 0) ? m_q[0] : m_last));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hold the button 10 edges then release and let the debouncer settle
  task automatic press(input logic [7:0] v);
    sw_in = v; btn_in = 1;
    ticks(10);
    btn_in = 0;
    ticks(2 * D + 8);
  endtask

  // Press into empty storage and check VALID rises exactly on edge D+3
  task automatic press_latency(input logic [7:0] v, input string tag);
    sw_in = v; btn_in = 1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (e == int'(D) + 2) check({tag, "_pre"}, 32'(valid), 32'd0);
      if (e == int'(D) + 3) begin
        check({tag, "_rise"}, 32'(valid), 32'd1);
        check({tag, "_data"}, 32'(data), 32'(v));
      end
    end
    btn_in = 0;
    ticks(2 * D + 8);
  endtask

  task automatic read1();
    rd = 1; tick(); rd = 0;
  endtask

  initial begin
    model_reset();
    ticks(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    rst_n = 1;

    // Clean press with A5, then one read
    press_latency(8'hA5, "a5");
    check("a5_ovr", 32'(overrun), 32'd0);
    read1();
    check("a5_rd_valid", 32'(valid), 32'd0);
    check("a5_rd_data", 32'(data), 32'hA5);

    // Bouncing button never accepted
    sw_in = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      btn_in = (i % 4) < 2;
      tick();
      check("bounce_valid", 32'(valid), 32'd0);
    end
    btn_in = 0;
    ticks(12);
    check("bounce_end_valid", 32'(valid), 32'd0);
    press_latency(8'h3C, "after_bounce");
    read1();

`ifdef SWITCH_INPUT_PORT_FIFO_EN
    for (int i = 1; i <= 5; i++) press(8'(i));
    check("fifo_ovr", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("fifo_head", 32'(data), 32'(i));
      read1();
    end
    check("fifo_empty_valid", 32'(valid), 32'd0);
    check("fifo_empty_ovr", 32'(overrun), 32'd0);
`else
    press(8'h11);
    press(8'h22);
    check("single_data", 32'(data), 32'h11);
    check("single_ovr", 32'(overrun), 32'd1);
    read1();
    check("single_rd_valid", 32'(valid), 32'd0);
    check("single_rd_ovr", 32'(overrun), 32'd0);
`endif

    // Fill storage, then capture on the same edge as a read
    for (int i = 0; i < DEPTH; i++) press(8'h30 + 8'(i));
    sw_in = 8'h44; btn_in = 1;
    for (int e = 0; e < 10; e++) begin
      rd = (e == int'(D) + 3);
      tick();
      if (e == int'(D) + 3) begin
        check("cap_rd_valid", 32'(valid), 32'd1);
        check("cap_rd_ovr", 32'(overrun), 32'd0);
        check("cap_rd_data", 32'(data), (DEPTH == 1) ? 32'h44 : 32'h31);
      end
    end
    rd = 0; btn_in = 0;
    ticks(2 * D + 8);

    // Reset on edge 3 of a press with data pending; button still held after release
    sw_in = 8'h77; btn_in = 1;
    ticks(4);
    rst_n = 0;
    #1;
    check("midrst_valid", 32'(valid), 32'd0);
    ticks(2);
    rst_n = 1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (e <= int'(D) + 2) check("rst_press_pre", 32'(valid), 32'd0);
      if (e == int'(D) + 3) begin
        check("rst_press_rise", 32'(valid), 32'd1);
        check("rst_press_data", 32'(data), 32'h77);
      end
    end
    btn_in = 0;
    ticks(2 * D + 8);

    // Random traffic: button runs of random length, random reads, rare resets
    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
        if (hold == 0) begin
          btn_in = ~btn_in;
          hold = int'($urandom_range(1, 3 * D + 4));
        end
        hold--;
        sw_in = 8'($urandom);
        rd = ($urandom_range(0, 7) == 0);
        if (!rst_n) rst_n = 1;
        else if ($urandom_range(0, 599) == 0) rst_n = 0;
        tick();
      end
      rd = 0;
      rst_n = 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_input_port.md
SWITCH_INPUT_PORT -- requirements
Module: switch_input_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of consecutive stable CLK cycles (range 2..65535) required to accept a new BTN_IN level.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 SW_IN  input  8  SHALL be the raw, unsynchronised switch bank (data to capture).
REQ-005 BTN_IN  input  1  SHALL be the raw, bouncing "enter" button; a debounced press captures SW_IN.
REQ-006 RD  input  1  SHALL be the CPU load strobe for this port's address, one CLK cycle wide per read.
REQ-007 DATA  output  8  SHALL present the oldest captured, unread switch value to the CPU memory bus.
REQ-008 VALID  output  1  SHALL be high while at least one captured value is unread.
REQ-009 OVERRUN  output  1  SHALL be a sticky flag: a capture was dropped because storage was full.

Function
REQ-010 SW_IN and BTN_IN SHALL each pass through a 2-flop synchroniser before any other use.
REQ-011 Button debouncer SHALL be a 4-state FSM: IDLE -> PRESS_WAIT (sync'd button high) -> PRESSED (high for DEBOUNCE_CYCLES consecutive cycles) -> RELEASE_WAIT (sync'd button low) -> IDLE (low for DEBOUNCE_CYCLES consecutive cycles).
REQ-012 In PRESS_WAIT or RELEASE_WAIT, any opposite-level sample SHALL return the FSM to the prior stable state and clear the debounce counter.
REQ-013 Debounce counter SHALL be 16 bits, SHALL saturate rather than wrap, and SHALL be cleared on every state transition.
REQ-014 On the PRESS_WAIT -> PRESSED transition only, the sync'd SW_IN SHALL be captured once; holding the button SHALL NOT produce repeat captures.
REQ-015 Latency: with BTN_IN held high from edge 0, VALID SHALL rise on edge DEBOUNCE_CYCLES+3.
REQ-016 RD with VALID high SHALL consume the value: VALID (single-register mode) clears on the next edge, and DATA holds its last value.
REQ-017 RD with VALID low SHALL have no effect on any state.
REQ-018 A capture and an RD in the same cycle with storage full SHALL both take effect: the old value is consumed, the new value is stored, VALID stays high, and OVERRUN is not set.
REQ-019 A capture with storage full and no same-cycle RD SHALL be dropped, keep stored data unchanged and set OVERRUN.
REQ-020 OVERRUN SHALL clear only on an RD that leaves storage empty, or on reset.

Reset
REQ-021 While RESET is low: FSM = IDLE, counter = 0, synchronisers = 0, DATA = 8'h00, VALID = 0, OVERRUN = 0, FIFO pointers/count = 0.
REQ-022 Reset asserted mid-debounce or with unread data SHALL discard all pending state with no capture on release.
REQ-023 After RESET rises, a button already held high SHALL be treated as a new press through the full debounce sequence.

Configuration
REQ-024 Macro SWITCH_INPUT_PORT_FIFO_EN defined: storage SHALL be a 4-entry FIFO with 2-bit wrapping pointers and a 3-bit count, DATA = head entry, VALID = (count != 0), full = (count == 4).
REQ-025 Macro SWITCH_INPUT_PORT_FIFO_EN undefined: storage SHALL be a single 8-bit register, with full = VALID; all other behaviour is identical.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-026 SW_IN=8'hA5, clean BTN_IN pulse held 10 cycles -> VALID rises on edge 7, DATA=8'hA5, OVERRUN=0; RD one cycle -> VALID=0, DATA stays 8'hA5.
REQ-027 BTN_IN toggling every 2 cycles for 20 cycles, then low -> VALID never rises, FSM back in IDLE.
REQ-028 Single-register mode, press with SW_IN=8'h11, then a second press with SW_IN=8'h22 without RD -> DATA=8'h11, OVERRUN=1; RD -> VALID=0, OVERRUN=0.
REQ-029 FIFO mode, five presses with values 1..5 and no RD -> OVERRUN=1; four RDs return 1,2,3,4, then VALID=0 and OVERRUN=0.
REQ-030 RESET pulsed low on edge 3 of a press, with BTN_IN still high after release -> no capture until a full debounce completes; VALID rises DEBOUNCE_CYCLES+3 edges after RESET rises.
REQ-031 Storage full, with the capture edge coinciding with RD -> VALID stays 1, DATA = the newly captured value (single mode), OVERRUN=0.
